// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The op constants are also imported by the controller decoder.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic opIsSigned(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute-stage controller and the
// multiply/divide unit.
interface muldiv_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         wr_hi;
  logic         wr_lo;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, A, B, wr_hi, wr_lo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, A, B, wr_hi, wr_lo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, signs applied in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input logic     clk,
  input logic     resetn,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(N);

  muldiv_state_t  state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [1:0]     op_q, op_d;
  logic           signA_q, signA_d;
  logic           signB_q, signB_d;
  logic           divZero_q, divZero_d;
  logic           dbz_q, dbz_d;
  logic [CW-1:0]  count_q, count_d;

  logic           startSigned, startNegA, startNegB, negResult;
  logic [N-1:0]   absA, absB, quot, rem;
  logic [N:0]     addSum, partial, diff;
  logic [2*N-1:0] product;

  // Multiply keeps {partial product, multiplier} in acc with the multiplicand
  // in opnd; divide keeps {remainder, dividend/quotient} with the divisor in opnd.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    op_d        = op_q;
    signA_d     = signA_q;
    signB_d     = signB_q;
    divZero_d   = divZero_q;
    count_d     = count_q;
    dbz_d       = 1'b0;

    startSigned = opIsSigned(bus.op);
    startNegA   = startSigned & bus.A[N-1];
    startNegB   = startSigned & bus.B[N-1];
    absA        = startNegA ? -bus.A : bus.A;
    absB        = startNegB ? -bus.B : bus.B;
    negResult   = opIsSigned(op_q) & (signA_q ^ signB_q);

    addSum      = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    partial     = acc_q[2*N-1:N-1];
    diff        = partial - {1'b0, opnd_q};
    product     = negResult ? -acc_q : acc_q;
    quot        = negResult ? -acc_q[N-1:0] : acc_q[N-1:0];
    rem         = signA_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d      = bus.op;
          signA_d   = startNegA;
          signB_d   = startNegB;
          divZero_d = (bus.B == '0);
          count_d   = '0;
          if (opIsDiv(bus.op)) begin
            opnd_d = absB;
            acc_d  = {{N{1'b0}}, absA};
          end else begin
            opnd_d = absA;
            acc_d  = {{N{1'b0}}, absB};
          end
          state_d = ST_RUN;
        end else begin
          if (bus.wr_hi) hi_d = bus.wdata;
          if (bus.wr_lo) lo_d = bus.wdata;
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (opIsDiv(op_q)) begin
          if (!diff[N]) acc_d = {diff[N-1:0], acc_q[N-2:0], 1'b1};
          else          acc_d = {partial[N-1:0], acc_q[N-2:0], 1'b0};
        end else begin
          acc_d = {addSum, acc_q[N-1:1]};
        end
        if (count_q == CW'(N-1)) state_d = ST_FIX;
        else                     count_d = count_q + 1'b1;
      end

      // A zero divisor leaves the dividend magnitude as the remainder, so
      // re-signing it reproduces A exactly; only the quotient is forced.
      ST_FIX: begin
        if (opIsDiv(op_q)) begin
          hi_d  = rem;
          lo_d  = divZero_q ? '1 : quot;
          dbz_d = divZero_q;
        end else begin
          hi_d = product[2*N-1:N];
          lo_d = product[N-1:0];
        end
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= OP_MULTU;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      dbz_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      divZero_q <= divZero_d;
      dbz_q     <= dbz_d;
      count_q   <= count_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  muldiv_if #(.N(N)) bus ();

  muldiv_unit #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [N-1:0] lastHi = '0;
  logic [N-1:0] lastLo = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic void refModel(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] hi, output logic [N-1:0] lo, output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      OP_MULTU: begin
        p  = 64'(a) * 64'(b);
        hi = p[63:32];
        lo = p[31:0];
      end
      OP_MULT: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          hi  = a;
          lo  = '1;
          dbz = 1'b1;
        end else if (op == OP_DIVU) begin
          lo = a / b;
          hi = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = N'(q);
          hi = N'(r);
        end
      end
    endcase
  endfunction

  // Launches one op in the current cycle and follows it to its done pulse;
  // with poke set, a stray start/MTHI is thrown at it mid-flight.
  task automatic applyStimulus(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                               input bit poke, input string tag);
    logic [N-1:0] eHi, eLo;
    logic eDbz;
    int cycles;
    refModel(op, a, b, eHi, eLo, eDbz);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
    cycles    = 0;
    do begin
      tick();
      cycles++;
      if (cycles == 1) checkOutput({tag, "_busy_early"}, 64'(bus.busy), 64'(1));
      if (cycles == 5) begin
        checkOutput({tag, "_hi_hold"}, 64'(bus.hi), 64'(lastHi));
        checkOutput({tag, "_lo_hold"}, 64'(bus.lo), 64'(lastLo));
        if (poke) begin
          bus.start = 1'b1;
          bus.wr_hi = 1'b1;
          bus.wdata = $urandom;
          bus.A     = $urandom;
          bus.B     = $urandom;
        end
      end
      if (cycles == 6) begin
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
      end
      if (cycles == 32) begin
        checkOutput({tag, "_busy_late"}, 64'(bus.busy), 64'(1));
        checkOutput({tag, "_dbz_busy"}, 64'(bus.div_by_zero), 64'(0));
      end
    end while (!bus.done && cycles < 100);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(33));
    checkOutput({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(eHi));
    checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(eLo));
    checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(eDbz));
    lastHi = eHi;
    lastLo = eLo;
  endtask

  initial begin
    logic [1:0]   rOp;
    logic [N-1:0] rA, rB;
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.A     = '0;
    bus.B     = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    checkOutput("rst_hi", 64'(bus.hi), 64'(0));
    checkOutput("rst_lo", 64'(bus.lo), 64'(0));
    resetn = 1'b1;
    tick();

    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    checkOutput("multu_max_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("multu_max_lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
    tick();
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg");
    checkOutput("mult_neg_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    tick();
    applyStimulus(OP_MULT, 32'h80000000, 32'h80000000, 1'b0, "mult_min");
    checkOutput("mult_min_hi_const", 64'(bus.hi), 64'h0000_0000_4000_0000);
    tick();
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
    checkOutput("div_neg_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    tick();
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu_small");
    checkOutput("divu_small_lo_const", 64'(bus.lo), 64'd14);
    tick();
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    checkOutput("div_ovf_lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    tick();
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b0, "divu_zero");
    tick();
    checkOutput("dbz_cleared", 64'(bus.div_by_zero), 64'(0));

    // Mid-flight start/MTHI must be ignored, then a back-to-back launch from DONE.
    applyStimulus(OP_DIVU, $urandom, 32'd3, 1'b1, "poke");
    applyStimulus(OP_MULT, $urandom, $urandom, 1'b0, "b2b");
    tick();

    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h1234;
    tick();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    checkOutput("mt_hi", 64'(bus.hi), 64'h1234);
    checkOutput("mt_lo", 64'(bus.lo), 64'h1234);
    lastHi = 32'h1234;
    lastLo = 32'h1234;

    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      case ($urandom_range(0, 7))
        0:       rB = '0;
        1:       rB = '1;
        2:       rB = N'($urandom_range(1, 15));
        3:       rA = 32'h80000000;
        default: rB = $urandom;
      endcase
      if (rA == 32'h80000000) rB = $urandom;
      applyStimulus(rOp, rA, rB, 1'b0, "rand");
      tick();
    end

    // Reset in the middle of a divide aborts it and clears hi/lo.
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.A     = $urandom;
    bus.B     = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    resetn = 1'b0;
    tick();
    checkOutput("abort_busy", 64'(bus.busy), 64'(0));
    checkOutput("abort_done", 64'(bus.done), 64'(0));
    checkOutput("abort_hi", 64'(bus.hi), 64'(0));
    checkOutput("abort_lo", 64'(bus.lo), 64'(0));
    resetn = 1'b1;
    lastHi = '0;
    lastLo = '0;
    tick();
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b0, "after_rst");
    checkOutput("after_rst_lo_const", 64'(bus.lo), 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
